// File: rtl/clk_ratio_ctrl.sv
// rtl/clk_ratio_ctrl.sv - runtime-programmable fast-to-slow clock divider controller
// Ratio changes are sequenced glitch-free: drain high phase, quiet low, reload, restart.
module clk_ratio_ctrl #(
   parameter int CNT_W        = 8,
   parameter int DEFAULT_DIV  = 4,
   parameter int QUIET_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic             slow_clk,
   output logic             rise_pre,
   output logic             fall_pre,
   output logic [CNT_W-1:0] div_cur,
   output logic             busy
);

   localparam int HOLD_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  DEF_DIV   = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0]  DEF_HALF  = CNT_W'(DEFAULT_DIV / 2 - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(QUIET_CYCLES - 1);

   typedef enum logic [2:0] {INIT, RUN, DRAIN, HOLD, RELOAD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  half_cnt;
   logic [CNT_W-1:0]  div_new;
   logic [HOLD_W-1:0] hold_cnt;

   logic             toggle;
   logic             counting;
   logic             cfg_ok;
   logic [CNT_W-1:0] half_reload;
   logic [CNT_W-1:0] half_new;

   assign toggle      = (half_cnt == '0);
   assign counting    = (state == RUN) || (state == DRAIN);
   assign cfg_ok      = !cfg_div[0] && (cfg_div != '0);
   assign half_reload = {1'b0, div_cur[CNT_W-1:1]} - CNT_W'(1);
   assign half_new    = {1'b0, div_new[CNT_W-1:1]} - CNT_W'(1);

   assign cfg_ready = (state == RUN);
   assign busy      = (state == DRAIN) || (state == HOLD) || (state == RELOAD);
   assign rise_pre  = counting && toggle && !slow_clk;
   assign fall_pre  = counting && toggle && slow_clk;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= INIT;
         slow_clk <= 1'b0;
         half_cnt <= DEF_HALF;
         div_cur  <= DEF_DIV;
         div_new  <= DEF_DIV;
         hold_cnt <= HOLD_INIT;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            INIT: state <= RUN;
            RUN: begin
               if (toggle) begin
                  slow_clk <= !slow_clk;
                  half_cnt <= half_reload;
               end else begin
                  half_cnt <= half_cnt - CNT_W'(1);
               end
               if (cfg_valid) begin
                  if (!cfg_ok) begin
                     cfg_err <= 1'b1;
                  end else begin
                     div_new <= cfg_div;
                     // A high phase in progress (or starting now) must finish first
                     if (slow_clk || toggle) begin
                        state <= DRAIN;
                     end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_INIT;
                     end
                  end
               end
            end
            DRAIN: begin
               if (toggle) begin
                  slow_clk <= !slow_clk;
                  half_cnt <= half_reload;
                  if (slow_clk) begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_INIT;
                  end
               end else begin
                  half_cnt <= half_cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (hold_cnt == '0) state <= RELOAD;
               else                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            RELOAD: begin
               div_cur  <= div_new;
               half_cnt <= half_new;
               cfg_done <= 1'b1;
               state    <= RUN;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// tb/tb_clk_ratio_ctrl.sv - directed-vector bench for clk_ratio_ctrl
module tb_clk_ratio_ctrl;

   logic       clk;
   logic       reset;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_done;
   logic       cfg_err;
   logic       slow_clk;
   logic       rise_pre;
   logic       fall_pre;
   logic [7:0] div_cur;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int ready_cnt;

   clk_ratio_ctrl #(.CNT_W(8), .DEFAULT_DIV(4), .QUIET_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
      .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .slow_clk(slow_clk), .rise_pre(rise_pre), .fall_pre(fall_pre),
      .div_cur(div_cur), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bits[i] is the expected slow_clk after the (i+1)-th following edge
   task automatic expect_wave(input string tag, input int n, input logic [15:0] bits);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, 32'(slow_clk), 32'(bits[i]));
      end
   endtask

   initial begin
      reset = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
      tick(); tick();
      chk("rst_slow", 32'(slow_clk), 0);
      chk("rst_div", 32'(div_cur), 4);
      chk("rst_ready", 32'(cfg_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(cfg_done), 0);
      chk("rst_err", 32'(cfg_err), 0);
      chk("rst_rise", 32'(rise_pre), 0);
      chk("rst_fall", 32'(fall_pre), 0);
      reset = 1'b1;

      tick();  // edge 1: INIT -> RUN
      chk("e1_ready", 32'(cfg_ready), 1);
      chk("e1_slow", 32'(slow_clk), 0);
      chk("e1_rise", 32'(rise_pre), 0);
      tick();
      chk("e2_rise", 32'(rise_pre), 1);
      chk("e2_slow", 32'(slow_clk), 0);
      tick();
      chk("e3_slow", 32'(slow_clk), 1);
      chk("e3_rise", 32'(rise_pre), 0);
      tick();
      chk("e4_fall", 32'(fall_pre), 1);
      tick();
      chk("e5_slow", 32'(slow_clk), 0);
      tick(); tick();
      chk("e7_slow", 32'(slow_clk), 1);

      // change to 8 while high: drain, hold, reload
      cfg_valid = 1'b1; cfg_div = 8'd8;
      tick();
      chk("d8_busy", 32'(busy), 1);
      chk("d8_ready", 32'(cfg_ready), 0);
      chk("d8_fallpre", 32'(fall_pre), 1);
      chk("d8_slow_high", 32'(slow_clk), 1);
      cfg_valid = 1'b0;
      tick();
      chk("d8_fell", 32'(slow_clk), 0);
      chk("d8_busy_hold", 32'(busy), 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("d8_busy_seq", 32'(busy), 1);
         chk("d8_rise_forced", 32'(rise_pre), 0);
      end
      tick();
      chk("d8_done", 32'(cfg_done), 1);
      chk("d8_div", 32'(div_cur), 8);
      chk("d8_busy_end", 32'(busy), 0);
      chk("d8_ready_end", 32'(cfg_ready), 1);
      expect_wave("d8_wave", 12, 16'b0000_1000_0111_1000);
      tick(); tick(); tick(); tick();
      chk("d6_pre_low", 32'(slow_clk), 0);

      // change to 6 while low: straight to hold
      cfg_valid = 1'b1; cfg_div = 8'd6;
      tick();
      chk("d6_busy", 32'(busy), 1);
      chk("d6_slow", 32'(slow_clk), 0);
      cfg_valid = 1'b0;
      tick(); chk("d6_busy2", 32'(busy), 1);
      tick(); chk("d6_busy3", 32'(busy), 1);
      tick();
      chk("d6_busy_end", 32'(busy), 0);
      chk("d6_done", 32'(cfg_done), 1);
      chk("d6_div", 32'(div_cur), 6);
      expect_wave("d6_wave", 9, 16'b0000_0001_0001_1100);

      // odd and zero ratios are rejected without disturbing the clock
      cfg_valid = 1'b1; cfg_div = 8'd5;
      tick();
      chk("e5_err", 32'(cfg_err), 1);
      chk("e5_ready", 32'(cfg_ready), 1);
      chk("e5_div", 32'(div_cur), 6);
      chk("e5_slow", 32'(slow_clk), 1);
      cfg_div = 8'd0;
      tick();
      chk("e0_err", 32'(cfg_err), 1);
      chk("e0_done", 32'(cfg_done), 0);
      chk("e0_div", 32'(div_cur), 6);
      cfg_valid = 1'b0;
      tick();
      chk("e_err_clear", 32'(cfg_err), 0);
      chk("e_slow_fall", 32'(slow_clk), 0);
      expect_wave("e_wave", 3, 16'b0000_0000_0000_0100);

      // valid held through a change: one acceptance, then another after RUN
      cfg_valid = 1'b1; cfg_div = 8'd6;
      ready_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         ready_cnt += int'(cfg_ready);
      end
      chk("hv_ready_busy", 32'(ready_cnt), 0);
      tick();
      chk("hv_done1", 32'(cfg_done), 1);
      chk("hv_ready1", 32'(cfg_ready), 1);
      tick();
      chk("hv_busy2", 32'(busy), 1);
      cfg_valid = 1'b0;
      tick(); tick(); tick();
      chk("hv_done2", 32'(cfg_done), 1);
      chk("hv_div", 32'(div_cur), 6);

      // reset during HOLD aborts the change
      cfg_valid = 1'b1; cfg_div = 8'd10;
      tick();
      chk("rh_busy", 32'(busy), 1);
      cfg_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("rh_slow", 32'(slow_clk), 0);
      chk("rh_busy_clr", 32'(busy), 0);
      chk("rh_div", 32'(div_cur), 4);
      chk("rh_ready", 32'(cfg_ready), 0);
      tick();
      reset = 1'b1;
      tick();
      chk("rr_e1_ready", 32'(cfg_ready), 1);
      chk("rr_e1_slow", 32'(slow_clk), 0);
      tick();
      chk("rr_e2_rise", 32'(rise_pre), 1);
      expect_wave("rr_wave", 6, 16'b0000_0000_0011_0011);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clk_ratio_ctrl.md
Name: clk_ratio_ctrl

Overview:
- Runtime-programmable controller for the synth-testbench memory-to-DLA clock divider.
- Generates the slow (axi_slave / DLA) clock from the fast memory clock.
- Accepts divide-ratio change requests over a valid/ready handshake and sequences each change glitch-free: drain the high phase, hold low for a quiet period, reload, restart aligned.
- Emits one-fast-cycle pre-edge strobes so fast-domain logic can launch data aligned to slow-clock edges.

Parameters:
- CNT_W, 8: width of divide ratio and internal counters.
- DEFAULT_DIV, 4: ratio after reset; even, 2..2^CNT_W-2.
- QUIET_CYCLES, 2: fast cycles slow_clk is held low between drain and reload; at least 1.

Ports:
- clk  in  1  fast (memory) clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  ratio change request.
- cfg_div  in  CNT_W  requested ratio; sampled on acceptance.
- cfg_ready  out  1  high only in RUN.
- cfg_done  out  1  one-cycle pulse: new ratio in effect.
- cfg_err  out  1  one-cycle pulse: request rejected.
- slow_clk  out  1  divided clock, registered.
- rise_pre  out  1  high in the cycle before slow_clk rises.
- fall_pre  out  1  high in the cycle before slow_clk falls.
- div_cur  out  CNT_W  ratio currently in effect.
- busy  out  1  high in DRAIN, HOLD and RELOAD.

Behaviour:
- Reset values: state INIT, slow_clk 0, half_cnt=DEFAULT_DIV/2-1, div_cur=DEFAULT_DIV, cfg_ready 0, cfg_done 0, cfg_err 0, rise_pre 0, fall_pre 0, busy 0.
- Reset is asynchronous. Asserting it mid-sequence aborts any change and discards the pending ratio.
- INIT lasts exactly one cycle with half_cnt held, then goes to RUN.
- RUN, each cycle:
  - half_cnt!=0: decrement.
  - half_cnt==0: toggle slow_clk and reload half_cnt=div_cur/2-1.
  - Period is div_cur fast cycles, 50% duty.
- Pre-edge strobes (combinational from registered state):
  - rise_pre = (state in RUN/DRAIN) & half_cnt==0 & !slow_clk.
  - fall_pre = (state in RUN/DRAIN) & half_cnt==0 & slow_clk.
  - Both are forced 0 in INIT, HOLD and RELOAD.
- Handshake:
  - Accept when cfg_valid & cfg_ready; capture cfg_div into div_new.
  - If cfg_div is odd or <2: cfg_err pulses the next cycle, state stays RUN, counting is undisturbed.
  - If cfg_div==div_cur: treated as valid and goes through the full sequence.
- Accepted valid request:
  - slow_clk==1 (or toggling to 1 this cycle): go to DRAIN.
  - slow_clk==0 and not toggling this cycle: go to HOLD directly, with hold_cnt=QUIET_CYCLES-1.
- DRAIN: count normally. On the falling toggle, go to HOLD with slow_clk=0 and hold_cnt=QUIET_CYCLES-1. The high phase is never truncated.
- HOLD: slow_clk held 0; hold_cnt decrements; at 0 go to RELOAD.
- RELOAD, one cycle: div_cur<=div_new, half_cnt<=div_new/2-1, slow_clk stays 0. Next state RUN; cfg_done is high in that first RUN cycle.
- Low phase across a change is never shorter than the old half period. No high phase is ever shorter than div_cur/2.
- busy = state in {DRAIN, HOLD, RELOAD}. cfg_ready = state==RUN, with no combinational path from cfg_valid.
- cfg_valid held during busy is ignored. The requester must keep it asserted until ready, per the standard valid/ready rule.
- cfg_err and cfg_done are never asserted together.

Test Plan:
- Reset release, DEFAULT_DIV=4:
  - INIT at edge 1; slow_clk rises at edge 3, falls at edge 5, period 4.
  - rise_pre high in the cycle before edge 3; div_cur=4.
- Request cfg_div=8 while slow_clk high:
  - DRAIN until the fall.
  - HOLD 2 cycles, RELOAD 1 cycle.
  - cfg_done pulses; subsequent period is 8 with high 4.
  - No high pulse shorter than 2 cycles.
- Request cfg_div=6 while slow_clk low:
  - Goes directly to HOLD; low extended by 3 cycles plus 3.
  - Then period 6; busy high exactly 3 cycles.
- Request cfg_div=5, then cfg_div=0:
  - cfg_err pulse for each; cfg_ready stays 1; div_cur unchanged.
  - slow_clk period unaffected.
- cfg_valid held high through a change:
  - Exactly one acceptance; cfg_ready 0 during busy.
  - Second acceptance only after returning to RUN.
- Reset asserted mid-HOLD:
  - slow_clk 0 immediately; after release div_cur=DEFAULT_DIV.
  - Restart timing is identical to the first scenario.
